// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_pkg
// Purpose  : Shared constants, FSM encoding and PC helper for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  localparam logic [31:0] INST_NOP           = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK      = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Sequential PC; wraps naturally at the top of the 32-bit space.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_if
// Purpose  : Instruction-memory req/gnt + rvalid bus between fetch and ROM.
// Revision : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface
`default_nettype wire

// File: rtl/ifu_fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Purpose  : One-entry {addr,inst} holding slot with push/pop/flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] inst_i,
  output logic        full_o,
  output logic [31:0] addr_o,
  output logic [31:0] inst_o
);

  logic        full_q, full_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;

  // Flush wins; a simultaneous pop+push replaces the entry in place.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    inst_d = inst_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d = 1'b1;
      addr_d = addr_i;
      inst_d = inst_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      inst_q <= INST_NOP;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      inst_q <= inst_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign inst_o = inst_q;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Fetch stage: PC, single-outstanding imem fetch, jump redirect
//            with response kill, and a skid slot to absorb IF/ID stalls.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_en_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               hold_i,
  ifu_fetch_if.master        imem,
  output logic               inst_valid_o,
  output logic [31:0]        inst_addr_o,
  output logic [31:0]        inst_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_addr_q, out_addr_d;
  logic [31:0]  out_inst_q, out_inst_d;

  logic         w_skid_push;
  logic         w_skid_pop;
  logic         w_skid_full;
  logic [31:0]  w_skid_addr;
  logic [31:0]  w_skid_inst;

  logic         w_req;
  logic         w_fire;
  logic         w_rsp;
  logic         w_rsp_ok;
  logic         w_consume;
  logic [31:0]  w_jump_target;

  assign w_jump_target = jump_addr_i & PC_ALIGN_MASK;
  assign w_req         = (state_q == ST_REQ) && !w_skid_full;
  assign w_fire        = w_req && imem.gnt;
  assign w_rsp         = (state_q == ST_WAIT) && imem.rvalid;
  // A response is kept only if no redirect has made it stale.
  assign w_rsp_ok      = w_rsp && !kill_q && !jump_en_i;
  assign w_consume     = out_valid_q && !hold_i;

  // Control FSM, PC and kill flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (w_fire) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (w_rsp_ok) pc_d = pc_incr(pc_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (jump_en_i) begin
      pc_d = w_jump_target;
      if (w_fire || ((state_q == ST_WAIT) && !imem.rvalid)) kill_d = 1'b1;
    end
  end

  // Output register and skid steering.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_inst_d  = out_inst_q;
    w_skid_push = 1'b0;
    w_skid_pop  = 1'b0;
    if (jump_en_i) begin
      out_valid_d = 1'b0;
      out_inst_d  = INST_NOP;
    end else if (w_consume) begin
      if (w_skid_full) begin
        out_valid_d = 1'b1;
        out_addr_d  = w_skid_addr;
        out_inst_d  = w_skid_inst;
        w_skid_pop  = 1'b1;
        w_skid_push = w_rsp_ok;
      end else if (w_rsp_ok) begin
        out_valid_d = 1'b1;
        out_addr_d  = pc_q;
        out_inst_d  = imem.rdata;
      end else begin
        out_valid_d = 1'b0;
        out_inst_d  = INST_NOP;
      end
    end else if (w_rsp_ok) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_addr_d  = pc_q;
        out_inst_d  = imem.rdata;
      end else begin
        w_skid_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_ADDR;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_inst_q  <= INST_NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_inst_q  <= out_inst_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_skid_push),
    .pop_i   (w_skid_pop),
    .flush_i (jump_en_i),
    .addr_i  (pc_q),
    .inst_i  (imem.rdata),
    .full_o  (w_skid_full),
    .addr_o  (w_skid_addr),
    .inst_o  (w_skid_inst)
  );

  assign imem.req     = w_req;
  assign imem.addr    = pc_q;
  assign inst_valid_o = out_valid_q;
  assign inst_addr_o  = out_addr_q;
  assign inst_o       = out_valid_q ? out_inst_q : INST_NOP;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench: ROM responder plus architectural fetch-stream
//            scoreboard (expected PC sequence with redirects).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        jen;
  logic [31:0] jaddr;
  logic        valid;
  logic [31:0] iaddr;
  logic [31:0] inst;

  ifu_fetch_if imem_if ();

  ifu_fetch #(.RESET_ADDR(RADDR)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jen),
    .jump_addr_i  (jaddr),
    .hold_i       (hold),
    .imem         (imem_if),
    .inst_valid_o (valid),
    .inst_addr_o  (iaddr),
    .inst_o       (inst)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ROM model controls and state
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        m_pending = 1'b0;
  logic        m_hs = 1'b0;
  logic [31:0] m_hs_addr = '0;
  logic [31:0] m_paddr = '0;
  int          m_cnt = 0;

  // Scoreboard state
  logic [31:0] exp_pc = RADDR;
  logic [31:0] last_cons = '0;
  logic        saw_wrap = 1'b0;
  int          n_cons = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ROM responder: grants randomly, returns data lat_min..lat_max cycles after gnt.
  initial begin
    imem_if.gnt    = 1'b0;
    imem_if.rvalid = 1'b0;
    imem_if.rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_if.rvalid = 1'b0;
      if (m_hs && !rst) begin
        chk("one_outstanding", {31'b0, m_pending}, 32'd0);
        chk("req_addr_aligned", {30'b0, m_hs_addr[1:0]}, 32'd0);
        m_pending = 1'b1;
        m_paddr   = m_hs_addr;
        m_cnt     = int'($urandom_range(lat_max, lat_min));
      end
      if (m_pending) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          imem_if.rvalid = 1'b1;
          imem_if.rdata  = rom(m_paddr);
          m_pending      = 1'b0;
        end
      end
      imem_if.gnt = (int'($urandom_range(99)) < gnt_pct);
      m_hs        = imem_if.req && imem_if.gnt;
      m_hs_addr   = imem_if.addr;
    end
  end

  // One clock: score the instruction consumed at the coming edge, then advance.
  task automatic cyc();
    logic was_jump;
    if (!rst && valid && !hold && !jen) begin
      chk("cons_addr", iaddr, exp_pc);
      chk("cons_inst", inst, rom(exp_pc));
      if (last_cons == 32'hFFFF_FFFC && iaddr == 32'h0) saw_wrap = 1'b1;
      last_cons = iaddr;
      exp_pc    = exp_pc + 32'd4;
      n_cons++;
    end
    was_jump = jen && !rst;
    if (was_jump) exp_pc = jaddr & 32'hFFFF_FFFC;
    @(negedge clk);
    #2;
    if (was_jump) chk("jump_flush_valid", {31'b0, valid}, 32'd0);
    if (!valid) chk("nop_when_invalid", inst, NOP);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_addr"}, iaddr, 32'd0);
    chk({tag, "_req"}, {31'b0, imem_if.req}, 32'd0);
  endtask

  initial begin
    int n;
    int c0;
    logic [31:0] a0;
    rst = 1'b1; hold = 1'b0; jen = 1'b0; jaddr = '0;

    // 1. reset, IDLE for one cycle, then free run with 1-cycle ROM
    repeat (2) begin @(negedge clk); #2; end
    check_reset_outputs("rst");
    rst = 1'b0; exp_pc = RADDR;
    cyc();
    chk("idle_one_cycle_req", {31'b0, imem_if.req}, 32'd1);
    chk("first_req_addr", imem_if.addr, RADDR);
    cyc();
    chk("first_valid_early", {31'b0, valid}, 32'd0);
    cyc();
    chk("first_valid", {31'b0, valid}, 32'd1);
    chk("first_addr", iaddr, RADDR);
    c0 = n_cons;
    repeat (16) cyc();
    chk("throughput_1_per_2", n_cons - c0, 32'd8);

    // 2. hold for 5 cycles with a response in flight
    a0 = iaddr;
    hold = 1'b1;
    repeat (5) begin
      cyc();
      chk("hold_addr_stable", iaddr, a0);
    end
    chk("hold_valid", {31'b0, valid}, 32'd1);
    chk("skid_full_blocks_req", {31'b0, imem_if.req}, 32'd0);
    hold = 1'b0;
    cyc();
    chk("release_next_pc", iaddr, a0 + 32'd4);
    repeat (12) cyc();

    // 3. jump during WAIT: late response killed, refetch at 0x100
    lat_min = 3; lat_max = 3;
    n = 0; while (!m_pending && n < 20) begin cyc(); n++; end
    chk("wait_pending_timeout", {31'b0, m_pending}, 32'd1);
    jen = 1'b1; jaddr = 32'h100; cyc(); jen = 1'b0;
    n = 0; while (!imem_if.req && n < 20) begin cyc(); n++; end
    chk("t3_req_addr", imem_if.addr, 32'h100);
    n = 0; while (!valid && n < 20) begin cyc(); n++; end
    chk("t3_first_valid", iaddr, 32'h100);

    // 4a. jump in REQ with gnt in the same cycle
    lat_min = 1; lat_max = 3; gnt_pct = 50;
    n = 0; while (!m_hs && n < 40) begin cyc(); n++; end
    chk("t4a_hs_timeout", {31'b0, m_hs}, 32'd1);
    jen = 1'b1; jaddr = 32'h200; cyc(); jen = 1'b0;
    n = 0; while (!valid && n < 40) begin cyc(); n++; end
    chk("t4a_first_valid", iaddr, 32'h200);

    // 4b. jump with rvalid in the same cycle
    n = 0; while (!imem_if.rvalid && n < 40) begin cyc(); n++; end
    chk("t4b_rvalid_timeout", {31'b0, imem_if.rvalid}, 32'd1);
    jen = 1'b1; jaddr = 32'h300; cyc(); jen = 1'b0;
    chk("t4b_req", {31'b0, imem_if.req}, 32'd1);
    chk("t4b_req_addr", imem_if.addr, 32'h300);
    n = 0; while (!valid && n < 40) begin cyc(); n++; end
    chk("t4b_first_valid", iaddr, 32'h300);

    // 5. unaligned target and PC wrap
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    jen = 1'b1; jaddr = 32'h103; cyc(); jen = 1'b0;
    n = 0; while (!valid && n < 20) begin cyc(); n++; end
    chk("t5_aligned_target", iaddr, 32'h100);
    jen = 1'b1; jaddr = 32'hFFFF_FFF8; cyc(); jen = 1'b0;
    repeat (16) cyc();
    chk("t5_pc_wrap", {31'b0, saw_wrap}, 32'd1);

    // 6. reset while WAIT with a response pending
    lat_min = 2; lat_max = 2;
    n = 0; while (!m_pending && n < 20) begin cyc(); n++; end
    chk("t6_pending_timeout", {31'b0, m_pending}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #2;
    check_reset_outputs("t6_rst");
    rst = 1'b0; exp_pc = RADDR;
    cyc();
    chk("t6_restart_req", {31'b0, imem_if.req}, 32'd1);
    chk("t6_restart_addr", imem_if.addr, RADDR);
    cyc();
    chk("t6_rvalid_ignored", {31'b0, valid}, 32'd0);
    repeat (8) cyc();

    // Randomized traffic: grant/latency jitter, stalls, sporadic redirects
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    c0 = n_cons;
    for (int i = 0; i < 600; i++) begin
      hold = (int'($urandom_range(99)) < 30);
      if (int'($urandom_range(99)) < 3) begin
        jen   = 1'b1;
        jaddr = $urandom;
      end
      cyc();
      jen = 1'b0;
    end
    hold = 1'b0;
    chk("rand_progress", {31'b0, (n_cons - c0) > 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
